// File: rtl/hazard_ctrl_mp.sv
// hazard_ctrl_mp: per-stage ENABLE/STALL/FLUSH control for the 5-stage core with N memory ports.
// Ports: CLK/RSTn (sync, active-low), EN, mem_busy_i/mem_req_o/pend_o (per port), branch/ex_busy/load-use inputs,
//        stage_ctrl_o (2 bits per stage, 0=PC_REG..4=MEM_WB; 0=ENABLE 1=STALL 2=FLUSH), timeout_o; HU_PERF_CNT_EN adds perf_*_o.
module hazard_ctrl_mp #(
  parameter int NUM_MEM_PORTS = 2,
  parameter int REG_AW        = 5,
  parameter int BR_FLUSH_N    = 1,
  parameter int TIMEOUT_CYC   = 1024
) (
  input  logic                     CLK,
  input  logic                     RSTn,
  input  logic                     EN,
  input  logic [NUM_MEM_PORTS-1:0] mem_busy_i,
  output logic [NUM_MEM_PORTS-1:0] mem_req_o,
  input  logic                     branch_taken_i,
  input  logic                     ex_busy_i,
  input  logic                     ld_en_i,
  input  logic [REG_AW-1:0]        ld_rd_i,
  input  logic [REG_AW-1:0]        rs1_i,
  input  logic [REG_AW-1:0]        rs2_i,
  input  logic                     rs1_used_i,
  input  logic                     rs2_used_i,
  output logic [9:0]               stage_ctrl_o,
  output logic [NUM_MEM_PORTS-1:0] pend_o,
  output logic                     timeout_o
`ifdef HU_PERF_CNT_EN
  ,
  output logic [31:0]              perf_stall_o,
  output logic [31:0]              perf_bubble_o,
  output logic [31:0]              perf_flush_o
`endif
);

  localparam logic [1:0] ENABLE = 2'd0;
  localparam logic [1:0] STALL  = 2'd1;
  localparam logic [1:0] FLUSH  = 2'd2;

  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYC);
  // Flag is registered, so it is armed one wait cycle early to be visible
  // during the TIMEOUT_CYC-th wait cycle.
  localparam logic [CW-1:0] CNT_SET = CW'(TIMEOUT_CYC - 1);

  typedef enum logic {RUN = 1'b0, MEM_WAIT = 1'b1} state_t;

  state_t                   state_q, state_d;
  logic [NUM_MEM_PORTS-1:0] pend_q, pend_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic                     timeout_q, timeout_d;
  logic [4:0][1:0]          ctrl;
  logic                     any_busy;
  logic                     load_use;

  assign any_busy = |mem_busy_i;
  assign load_use = ld_en_i && (ld_rd_i != '0) &&
                    ((rs1_used_i && (rs1_i == ld_rd_i)) ||
                     (rs2_used_i && (rs2_i == ld_rd_i)));

  // State register
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state_q   <= RUN;
      pend_q    <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    if (EN) begin
      case (state_q)
        RUN: begin
          if (any_busy) begin
            state_d = MEM_WAIT;
            pend_d  = mem_busy_i;
            cnt_d   = '0;
          end
        end
        MEM_WAIT: begin
          if (any_busy) begin
            pend_d = pend_q | mem_busy_i;
            if (cnt_q != CNT_MAX) cnt_d = cnt_q + CW'(1);
            if (cnt_d >= CNT_SET) timeout_d = 1'b1;
          end else begin
            state_d = RUN;
            pend_d  = '0;
            cnt_d   = '0;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  // Output logic. With no port busy the normal decode applies in either
  // state, so the release cycle of a wait already issues fresh control.
  always_comb begin
    ctrl      = {5{ENABLE}};
    mem_req_o = '1;
    if (!EN) begin
      ctrl      = {5{STALL}};
      mem_req_o = '0;
    end else if (any_busy) begin
      ctrl = {5{STALL}};
      // Requests fire on the first busy cycle only; while waiting they are held off.
      if (state_q == MEM_WAIT) mem_req_o = '0;
    end else if (ex_busy_i) begin
      ctrl[0] = STALL;
      ctrl[1] = STALL;
      ctrl[2] = STALL;
      ctrl[3] = FLUSH;
    end else if (load_use) begin
      ctrl[0] = STALL;
      ctrl[1] = STALL;
      ctrl[2] = FLUSH;
    end else if (branch_taken_i) begin
      ctrl[1] = FLUSH;
      if (BR_FLUSH_N == 2) ctrl[2] = FLUSH;
    end
  end

  assign stage_ctrl_o = ctrl;
  assign pend_o       = pend_q;
  assign timeout_o    = timeout_q;

`ifdef HU_PERF_CNT_EN
  logic [31:0] perf_stall_q, perf_bubble_q, perf_flush_q;
  logic        bubble_ev, flush_ev;

  assign bubble_ev = !any_busy && (ex_busy_i || load_use);
  assign flush_ev  = !any_busy && !ex_busy_i && !load_use && branch_taken_i;

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      perf_stall_q  <= '0;
      perf_bubble_q <= '0;
      perf_flush_q  <= '0;
    end else if (EN) begin
      if (ctrl[0] == STALL) perf_stall_q <= perf_stall_q + 32'd1;
      if (bubble_ev)        perf_bubble_q <= perf_bubble_q + 32'd1;
      if (flush_ev)         perf_flush_q <= perf_flush_q + 32'd1;
    end
  end

  assign perf_stall_o  = perf_stall_q;
  assign perf_bubble_o = perf_bubble_q;
  assign perf_flush_o  = perf_flush_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl_mp.sv
module tb_hazard_ctrl_mp;

  localparam logic [9:0] C_EN   = 10'h000;
  localparam logic [9:0] C_STL  = 10'h155;
  localparam logic [9:0] C_LU   = 10'h025;
  localparam logic [9:0] C_BR1  = 10'h008;
  localparam logic [9:0] C_BR2  = 10'h028;
  localparam logic [9:0] C_EXB  = 10'h095;

  logic       CLK = 1'b0;
  logic       RSTn;
  logic       EN;
  logic [1:0] mem_busy;
  logic       branch_taken, ex_busy, ld_en, rs1_used, rs2_used;
  logic [4:0] ld_rd, rs1, rs2;

  logic [1:0] req1, pend1, req2, pend2;
  logic [9:0] ctrl1, ctrl2;
  logic       to1, to2;

  int tests = 0;
  int fails = 0;

  always #5 CLK = ~CLK;

`ifdef HU_PERF_CNT_EN
  logic [31:0] ps1, pb1, pf1, ps2, pb2, pf2;
`endif

  hazard_ctrl_mp #(.NUM_MEM_PORTS(2), .REG_AW(5), .BR_FLUSH_N(1), .TIMEOUT_CYC(8)) dut1 (
    .CLK(CLK), .RSTn(RSTn), .EN(EN),
    .mem_busy_i(mem_busy), .mem_req_o(req1),
    .branch_taken_i(branch_taken), .ex_busy_i(ex_busy),
    .ld_en_i(ld_en), .ld_rd_i(ld_rd), .rs1_i(rs1), .rs2_i(rs2),
    .rs1_used_i(rs1_used), .rs2_used_i(rs2_used),
    .stage_ctrl_o(ctrl1), .pend_o(pend1), .timeout_o(to1)
`ifdef HU_PERF_CNT_EN
    , .perf_stall_o(ps1), .perf_bubble_o(pb1), .perf_flush_o(pf1)
`endif
  );

  hazard_ctrl_mp #(.NUM_MEM_PORTS(2), .REG_AW(5), .BR_FLUSH_N(2), .TIMEOUT_CYC(4)) dut2 (
    .CLK(CLK), .RSTn(RSTn), .EN(EN),
    .mem_busy_i(mem_busy), .mem_req_o(req2),
    .branch_taken_i(branch_taken), .ex_busy_i(ex_busy),
    .ld_en_i(ld_en), .ld_rd_i(ld_rd), .rs1_i(rs1), .rs2_i(rs2),
    .rs1_used_i(rs1_used), .rs2_used_i(rs2_used),
    .stage_ctrl_o(ctrl2), .pend_o(pend2), .timeout_o(to2)
`ifdef HU_PERF_CNT_EN
    , .perf_stall_o(ps2), .perf_bubble_o(pb2), .perf_flush_o(pf2)
`endif
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic neg();
    @(negedge CLK);
  endtask

  task automatic clr_in();
    mem_busy = 2'b00; branch_taken = 0; ex_busy = 0;
    ld_en = 0; ld_rd = 0; rs1 = 0; rs2 = 0; rs1_used = 0; rs2_used = 0;
  endtask

  task automatic do_reset();
    RSTn = 0;
    cyc();
    cyc();
    RSTn = 1;
  endtask

  initial begin
    EN = 1;
    clr_in();
    #1;
    do_reset();

    // 1: idle after reset
    neg();
    chk("rst_ctrl", 16'(ctrl1), 16'(C_EN));
    chk("rst_req", 16'(req1), 16'h3);
    chk("rst_pend", 16'(pend1), 16'h0);
    chk("rst_to", 16'(to1), 16'h0);
    cyc();

    // 2: port 1 busy for the entry cycle plus 3 wait cycles
    mem_busy = 2'b10;
    neg();
    chk("w0_ctrl", 16'(ctrl1), 16'(C_STL));
    chk("w0_req", 16'(req1), 16'h3);
    cyc();
    for (int i = 1; i <= 3; i++) begin
      neg();
      chk($sformatf("w%0d_ctrl", i), 16'(ctrl1), 16'(C_STL));
      chk($sformatf("w%0d_req", i), 16'(req1), 16'h0);
      chk($sformatf("w%0d_pend", i), 16'(pend1), 16'h2);
      cyc();
    end
    mem_busy = 2'b00;
    neg();
    chk("rel_ctrl", 16'(ctrl1), 16'(C_EN));
    chk("rel_req", 16'(req1), 16'h3);
    cyc();
    neg();
    chk("post_pend", 16'(pend1), 16'h0);
    chk("post_to8", 16'(to1), 16'h0);
    cyc();

    // 3: load-use beats branch; x0 and unused operand do not stall
    ld_en = 1; ld_rd = 5; rs2 = 5; rs2_used = 1; branch_taken = 1;
    neg();
    chk("lu_ctrl", 16'(ctrl1), 16'(C_LU));
    chk("lu_req", 16'(req1), 16'h3);
    cyc();
    ld_rd = 0; rs2 = 0;
    neg();
    chk("lu_x0", 16'(ctrl1), 16'(C_BR1));
    cyc();
    ld_rd = 5; rs2 = 5; rs2_used = 0;
    neg();
    chk("lu_unused", 16'(ctrl1), 16'(C_BR1));
    cyc();
    rs1 = 5; rs1_used = 1;
    neg();
    chk("lu_rs1", 16'(ctrl1), 16'(C_LU));
    cyc();

    // 4: branch flush depth 2; ex_busy overrides branch and load-use
    clr_in();
    branch_taken = 1;
    neg();
    chk("br2_ctrl", 16'(ctrl2), 16'(C_BR2));
    cyc();
    ex_busy = 1;
    neg();
    chk("exb_ctrl", 16'(ctrl2), 16'(C_EXB));
    cyc();
    ld_en = 1; ld_rd = 7; rs1 = 7; rs1_used = 1;
    neg();
    chk("exb_over_lu", 16'(ctrl1), 16'(C_EXB));
    cyc();
    // memory busy overrides everything
    mem_busy = 2'b01;
    neg();
    chk("mem_over_ex", 16'(ctrl1), 16'(C_STL));
    cyc();
    // EN low freezes the wait
    clr_in();
    mem_busy = 2'b01;
    EN = 0;
    neg();
    chk("en0_ctrl", 16'(ctrl1), 16'(C_STL));
    chk("en0_req", 16'(req1), 16'h0);
    cyc();
    EN = 1;
    mem_busy = 2'b00;
    // release into a load-use hazard: decode applies in the release cycle
    ld_en = 1; ld_rd = 3; rs2 = 3; rs2_used = 1;
    neg();
    chk("en0_pend_hold", 16'(pend1), 16'h1);
    chk("rel_lu_ctrl", 16'(ctrl1), 16'(C_LU));
    chk("rel_lu_req", 16'(req1), 16'h3);
    cyc();
    neg();
    chk("rel_lu_pend", 16'(pend1), 16'h0);
    cyc();

    // 5: watchdog with TIMEOUT_CYC=4 on dut2
    clr_in();
    do_reset();
    neg();
    chk("to_rst", 16'(to2), 16'h0);
    cyc();
    mem_busy = 2'b01;
    neg();
    chk("to_c0", 16'(to2), 16'h0);
    cyc();
    for (int i = 1; i <= 5; i++) begin
      neg();
      chk($sformatf("to_w%0d", i), 16'(to2), (i >= 4) ? 16'h1 : 16'h0);
      cyc();
    end
    mem_busy = 2'b00;
    neg();
    chk("to_rel", 16'(to2), 16'h1);
    chk("to_rel_ctrl", 16'(ctrl2), 16'(C_EN));
    chk("to_dut1_clear", 16'(to1), 16'h0);
    cyc();
    neg();
    chk("to_sticky", 16'(to2), 16'h1);
    cyc();
    do_reset();
    neg();
    chk("to_cleared", 16'(to2), 16'h0);
    cyc();

    // 6: pend accumulation, partial drop, reset mid-wait
    mem_busy = 2'b01;
    cyc();
    mem_busy = 2'b11;
    neg();
    chk("acc_pend0", 16'(pend1), 16'h1);
    cyc();
    mem_busy = 2'b10;
    neg();
    chk("acc_pend1", 16'(pend1), 16'h3);
    chk("acc_ctrl", 16'(ctrl1), 16'(C_STL));
    chk("acc_req", 16'(req1), 16'h0);
    cyc();
    neg();
    chk("acc_pend2", 16'(pend1), 16'h3);
    chk("acc_req2", 16'(req1), 16'h0);
    RSTn = 0;
    cyc();
    RSTn = 1;
    mem_busy = 2'b00;
    neg();
    chk("mrst_ctrl", 16'(ctrl1), 16'(C_EN));
    chk("mrst_req", 16'(req1), 16'h3);
    chk("mrst_pend", 16'(pend1), 16'h0);
    cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
